// File: rtl/la_sample_reader.sv
// Logic-analyser read side: pops 64-bit capture words from the sample FIFO,
// unpacks them LSB byte first and streams exactly sample_num bytes to Ethernet TX.
module la_sample_reader #(
   parameter int DATA_WIDTH     = 64,
   parameter int BYTES_PER_WORD = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sample_run,
   input  logic [31:0]           sample_num,
   input  logic                  capture_done,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_empty,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  tx_last,
   output logic                  ethernet_read_done,
   output logic [2:0]            dbg_state
);

   localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_POP   = 3'd2,
      ST_LOAD  = 3'd3,
      ST_SEND  = 3'd4,
      ST_FLUSH = 3'd5
   } state_t;

   state_t                state;
   logic                  run_r0, run_r1, run_r2;
   logic                  start_pulse;
   logic                  done_seen;
   logic [31:0]           bytes_left;
   logic [IDX_W-1:0]      byte_idx;
   logic [IDX_W-1:0]      idx_nxt;
   logic [DATA_WIDTH-1:0] word_q;
   logic [7:0]            next_byte;

   assign dbg_state = state;

   // sample_run is asynchronous to clk; the rising edge becomes a one-cycle start_pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_r0      <= 1'b0;
         run_r1      <= 1'b0;
         run_r2      <= 1'b0;
         start_pulse <= 1'b0;
      end else begin
         run_r0      <= sample_run;
         run_r1      <= run_r0;
         run_r2      <= run_r1;
         start_pulse <= run_r1 & ~run_r2;
      end
   end

   always_comb begin
      idx_nxt   = byte_idx + 1'b1;
      next_byte = word_q[idx_nxt*8 +: 8];
   end

   // TX handshake: a byte transfers on a clock edge where tx_valid & tx_ready; while
   // tx_valid is high and tx_ready low, tx_data and tx_last hold their values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= ST_IDLE;
         fifo_rd_en         <= 1'b0;
         tx_data            <= 8'd0;
         tx_valid           <= 1'b0;
         tx_last            <= 1'b0;
         ethernet_read_done <= 1'b1;
         done_seen          <= 1'b0;
         bytes_left         <= 32'd0;
         byte_idx           <= '0;
         word_q             <= '0;
      end else begin
         fifo_rd_en <= 1'b0;
         if (state != ST_IDLE && capture_done) begin
            done_seen <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               done_seen <= 1'b0;
               if (start_pulse && sample_num != 32'd0) begin
                  bytes_left         <= sample_num;
                  ethernet_read_done <= 1'b0;
                  state              <= ST_FETCH;
               end
            end

            ST_FETCH: begin
               if (!fifo_empty) begin
                  fifo_rd_en <= 1'b1;
                  state      <= ST_POP;
               end
            end

            // fifo_rd_en is high during this cycle; read data lands on the next one.
            ST_POP: state <= ST_LOAD;

            ST_LOAD: begin
               word_q   <= fifo_rd_data;
               byte_idx <= '0;
               tx_data  <= fifo_rd_data[7:0];
               tx_valid <= 1'b1;
               tx_last  <= (bytes_left == 32'd1);
               state    <= ST_SEND;
            end

            ST_SEND: begin
               if (tx_valid && tx_ready) begin
                  bytes_left <= bytes_left - 32'd1;
                  if (bytes_left == 32'd1) begin
                     tx_valid <= 1'b0;
                     tx_last  <= 1'b0;
                     state    <= ST_FLUSH;
                  end else if (byte_idx == LAST_IDX) begin
                     tx_valid <= 1'b0;
                     tx_last  <= 1'b0;
                     if (!fifo_empty) begin
                        fifo_rd_en <= 1'b1;
                        state      <= ST_POP;
                     end else begin
                        state <= ST_FETCH;
                     end
                  end else begin
                     byte_idx <= idx_nxt;
                     tx_data  <= next_byte;
                     tx_last  <= (bytes_left == 32'd2);
                  end
               end
            end

            // Drain leftovers one pop at a time; empty is only trusted while no pop is in flight.
            ST_FLUSH: begin
               if (done_seen && !fifo_rd_en) begin
                  if (fifo_empty) begin
                     ethernet_read_done <= 1'b1;
                     state              <= ST_IDLE;
                  end else begin
                     fifo_rd_en <= 1'b1;
                  end
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
